// File: rtl/fifo_status_tracker_if.sv
// Status bundle between the write-side pointer logic and the FIFO status tracker.
// The tracker owns the slave modport; whoever supplies pointers drives the master modport.
interface fifo_status_tracker_if #(
    parameter int DATADEPTH = 16
);
    localparam int AW = $clog2(DATADEPTH);

    logic [AW-1:0] G_W_address;
    logic [AW-1:0] G_R_address;
    logic          w_en;
    logic          clr_err;
    logic          direction;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;

    modport master (
        output G_W_address, G_R_address, w_en, clr_err,
        input  direction, full, empty, level, almost_full, almost_empty, overflow
    );

    modport slave (
        input  G_W_address, G_R_address, w_en, clr_err,
        output direction, full, empty, level, almost_full, almost_empty, overflow
    );
endinterface

// File: rtl/fifo_status_tracker.sv
// Write-domain status for a gray-pointer FIFO: quadrant direction flag, registered
// full/empty, fill level, almost thresholds and a sticky overflow flag.
module fifo_status_tracker #(
    parameter int DATADEPTH = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic                   w_clk,
    input  logic                   w_rst,
    fifo_status_tracker_if.slave   st
);
    localparam int AW = $clog2(DATADEPTH);
    localparam int M  = AW - 1;

    function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
        logic [AW-1:0] b;
        b[AW-1] = g[AW-1];
        for (int i = AW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic          direction_q;
    logic          full_q;
    logic          empty_q;
    logic [AW:0]   level_q;
    logic          almost_full_q;
    logic          almost_empty_q;
    logic          overflow_q;

    logic          x1, x2;
    logic          dir_set, dir_clr, dir_nxt;
    logic          eq;
    logic [AW-1:0] diff;
    logic [AW:0]   level_nxt;
    logic          af_nxt, ae_nxt, ovf_nxt;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        x1        = 1'b0;
        x2        = 1'b0;
        dir_set   = 1'b0;
        dir_clr   = 1'b0;
        dir_nxt   = direction_q;
        eq        = 1'b0;
        diff      = '0;
        level_nxt = '0;
        af_nxt    = 1'b0;
        ae_nxt    = 1'b0;
        ovf_nxt   = overflow_q;

        // The two top gray bits identify the quadrant; a write one quadrant
        // behind the read means the FIFO is wrapping toward full.
        x1      = st.G_W_address[M] ^ st.G_R_address[M-1];
        x2      = st.G_W_address[M-1] ^ st.G_R_address[M];
        dir_set = x1 & ~x2;
        dir_clr = ~x1 & x2;
        if (dir_set) begin
            dir_nxt = 1'b1;
        end else if (dir_clr) begin
            dir_nxt = 1'b0;
        end

        eq   = (st.G_W_address == st.G_R_address);
        diff = gray2bin(st.G_W_address) - gray2bin(st.G_R_address);
        if (eq) begin
            level_nxt = dir_nxt ? (AW+1)'(DATADEPTH) : '0;
        end else begin
            level_nxt = {1'b0, diff};
        end

        af_nxt = (int'(level_nxt) >= AF_THRESH);
        ae_nxt = (int'(level_nxt) <= AE_THRESH);

        // Set dominates clear when both land in the same cycle.
        ovf_nxt = (st.w_en & full_q) | (overflow_q & ~st.clr_err);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            direction_q    <= 1'b0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            level_q        <= '0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
        end else begin
            direction_q    <= dir_nxt;
            full_q         <= eq & dir_nxt;
            empty_q        <= eq & ~dir_nxt;
            level_q        <= level_nxt;
            almost_full_q  <= af_nxt;
            almost_empty_q <= ae_nxt;
            overflow_q     <= ovf_nxt;
        end
    end

    assign st.direction    = direction_q;
    assign st.full         = full_q;
    assign st.empty        = empty_q;
    assign st.level        = level_q;
    assign st.almost_full  = almost_full_q;
    assign st.almost_empty = almost_empty_q;
    assign st.overflow     = overflow_q;
endmodule
